// File: rtl/teller_scheduler_pkg.sv
// Shared types and default sizing for the bank-queue teller scheduler.
package teller_scheduler_pkg;

  typedef enum logic [1:0] {T_OFF, T_READY, T_SERVING} teller_state_t;

  localparam int N_TELLERS_DEF = 3;
  localparam int MAX_Q_DEF     = 7;
  localparam int T_SVC_DEF     = 3;
  localparam int WAIT_W_DEF    = 6;

  // Index width that stays >= 1 even for a single teller.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/teller_scheduler_if.sv
// Sensor/teller-side inputs and display/call-side outputs of the scheduler.
interface teller_scheduler_if
  import teller_scheduler_pkg::*;
#(
  parameter int N_TELLERS = N_TELLERS_DEF,
  parameter int CNT_W     = $clog2(MAX_Q_DEF + 1),
  parameter int WAIT_W    = WAIT_W_DEF,
  parameter int ID_W      = idx_w(N_TELLERS)
);
  logic                 enter_pulse;
  logic [N_TELLERS-1:0] teller_on;
  logic [N_TELLERS-1:0] teller_done;
  logic                 call_valid;
  logic [ID_W-1:0]      call_id;
  logic [CNT_W-1:0]     q_count;
  logic                 q_full;
  logic                 q_empty;
  logic [WAIT_W-1:0]    wait_time;
  logic                 overflow;

  modport master (
    output enter_pulse, teller_on, teller_done,
    input  call_valid, call_id, q_count, q_full, q_empty, wait_time, overflow
  );

  modport slave (
    input  enter_pulse, teller_on, teller_done,
    output call_valid, call_id, q_count, q_full, q_empty, wait_time, overflow
  );
endinterface

// File: rtl/teller_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the index after the last winner.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req_i,
  input  logic          grant_en_i,
  output logic [N-1:0]  gnt_onehot_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_any_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] jj;
  logic          found;
  int            j;

  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    found        = 1'b0;
    j            = 0;
    jj           = '0;
    if (grant_en_i) begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr_q) + k;
        if (j >= N) j = j - N;
        jj = IW'(j);
        if (!found && req_i[jj]) begin
          found            = 1'b1;
          gnt_idx_o        = jj;
          gnt_onehot_o[jj] = 1'b1;
        end
      end
    end
  end

  assign gnt_any_o = found;

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + IW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/teller_scheduler.sv
// Bank queue sequencer: counts arrivals, calls waiting customers to ready
// tellers round-robin, and publishes occupancy and an estimated wait.
module teller_scheduler
  import teller_scheduler_pkg::*;
#(
  parameter int N_TELLERS = N_TELLERS_DEF,
  parameter int MAX_Q     = MAX_Q_DEF,
  parameter int T_SVC     = T_SVC_DEF,
  parameter int WAIT_W    = WAIT_W_DEF
) (
  input logic               clk,
  input logic               reset_n,
  teller_scheduler_if.slave sch
);
  localparam int CNT_W = $clog2(MAX_Q + 1);
  localparam int ID_W  = idx_w(N_TELLERS);
  localparam logic [CNT_W-1:0]  QMAX = CNT_W'(MAX_Q);
  localparam logic [WAIT_W-1:0] WMAX = '1;

  teller_state_t        st_q [N_TELLERS];
  teller_state_t        st_d [N_TELLERS];
  logic [N_TELLERS-1:0] req, gnt_oh;
  logic [ID_W-1:0]      gnt_idx, call_id_q;
  logic                 gnt_any, enter_acc;
  logic                 call_valid_q, overflow_q, q_full_q, q_empty_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  int                   n_on, prod, quo;

  // Teller FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_TELLERS; i++) st_q[i] <= T_OFF;
    end else begin
      for (int i = 0; i < N_TELLERS; i++) st_q[i] <= st_d[i];
    end
  end

  // Teller FSM: next state; going off duty overrides everything
  always_comb begin
    for (int i = 0; i < N_TELLERS; i++) begin
      st_d[i] = st_q[i];
      if (!sch.teller_on[i]) st_d[i] = T_OFF;
      else begin
        case (st_q[i])
          T_OFF:     st_d[i] = T_READY;
          T_READY:   if (gnt_oh[i]) st_d[i] = T_SERVING;
          T_SERVING: if (sch.teller_done[i]) st_d[i] = T_READY;
          default:   st_d[i] = T_OFF;
        endcase
      end
    end
  end

  // Teller FSM: outputs (grant requests)
  always_comb begin
    for (int i = 0; i < N_TELLERS; i++)
      req[i] = (st_q[i] == T_READY) && sch.teller_on[i];
  end

  rr_arbiter #(.N(N_TELLERS), .IW(ID_W)) u_arb (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_i        (req),
    .grant_en_i   (cnt_q != '0),
    .gnt_onehot_o (gnt_oh),
    .gnt_idx_o    (gnt_idx),
    .gnt_any_o    (gnt_any)
  );

  // A full queue still accepts an arrival when a grant frees a slot
  assign enter_acc = sch.enter_pulse && ((cnt_q != QMAX) || gnt_any);

  always_comb begin
    cnt_d = cnt_q;
    if (enter_acc && !gnt_any)      cnt_d = cnt_q + CNT_W'(1);
    else if (!enter_acc && gnt_any) cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    n_on   = $countones(sch.teller_on);
    prod   = int'(cnt_d) * T_SVC;
    quo    = 0;
    wait_d = '0;
    if (cnt_d == '0)    wait_d = '0;
    else if (n_on == 0) wait_d = WMAX;
    else begin
      quo    = (prod + n_on - 1) / n_on;
      wait_d = (quo > int'(WMAX)) ? WMAX : WAIT_W'(quo);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      q_full_q     <= 1'b0;
      q_empty_q    <= 1'b1;
      call_valid_q <= 1'b0;
      call_id_q    <= '0;
      overflow_q   <= 1'b0;
      wait_q       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      q_full_q     <= (cnt_d == QMAX);
      q_empty_q    <= (cnt_d == '0);
      call_valid_q <= gnt_any;
      call_id_q    <= gnt_idx;
      overflow_q   <= sch.enter_pulse && !enter_acc;
      wait_q       <= wait_d;
    end
  end

  assign sch.call_valid = call_valid_q;
  assign sch.call_id    = call_id_q;
  assign sch.q_count    = cnt_q;
  assign sch.q_full     = q_full_q;
  assign sch.q_empty    = q_empty_q;
  assign sch.wait_time  = wait_q;
  assign sch.overflow   = overflow_q;

endmodule

// File: tb/tb_teller_scheduler.sv
// Bench for teller_scheduler: directed scenarios plus random traffic, all
// outputs checked every cycle against a queue/teller model of the block.
module tb_teller_scheduler;
  localparam int N = 3, MAXQ = 7, TSVC = 3, WW = 6, CW = 3, IW = 2;
  localparam int WALL = (1 << WW) - 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  teller_scheduler_if #(.N_TELLERS(N), .CNT_W(CW), .WAIT_W(WW), .ID_W(IW)) bus ();

  teller_scheduler #(.N_TELLERS(N), .MAX_Q(MAXQ), .T_SVC(TSVC), .WAIT_W(WW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sch     (bus)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue length, teller roles (0 off, 1 ready, 2 serving), last winner
  int m_cnt, m_last, m_cv, m_id, m_ov, m_wait;
  int m_st [N];

  task automatic model_reset();
    m_cnt = 0; m_last = N - 1; m_cv = 0; m_id = 0; m_ov = 0; m_wait = 0;
    for (int i = 0; i < N; i++) m_st[i] = 0;
  endtask

  task automatic model_step();
    int g, acc, n, w;
    logic [IW-1:0] ix;
    logic [N-1:0] on, dn;
    on = bus.teller_on;
    dn = bus.teller_done;
    g = -1;
    if (m_cnt > 0)
      for (int k = 1; k <= N; k++) begin
        ix = IW'((m_last + k) % N);
        if (g < 0 && m_st[ix] == 1 && on[ix]) g = int'(ix);
      end
    acc  = (bus.enter_pulse && (m_cnt < MAXQ || g >= 0)) ? 1 : 0;
    m_ov = (bus.enter_pulse && acc == 0) ? 1 : 0;
    m_cnt = m_cnt + acc - ((g >= 0) ? 1 : 0);
    m_cv = (g >= 0) ? 1 : 0;
    if (g >= 0) begin m_id = g; m_last = g; end
    for (int i = 0; i < N; i++) begin
      ix = IW'(i);
      if (!on[ix])                      m_st[ix] = 0;
      else if (i == g)                  m_st[ix] = 2;
      else if (m_st[ix] == 0)           m_st[ix] = 1;
      else if (m_st[ix] == 2 && dn[ix]) m_st[ix] = 1;
    end
    n = $countones(on);
    if (m_cnt == 0)  m_wait = 0;
    else if (n == 0) m_wait = WALL;
    else begin
      w = (m_cnt * TSVC + n - 1) / n;
      m_wait = (w > WALL) ? WALL : w;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_step();
  end

  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1) begin
      chk("call_valid", int'(bus.call_valid), m_cv);
      if (m_cv != 0) chk("call_id", int'(bus.call_id), m_id);
      chk("q_count", int'(bus.q_count), m_cnt);
      chk("q_full", int'(bus.q_full), (m_cnt == MAXQ) ? 1 : 0);
      chk("q_empty", int'(bus.q_empty), (m_cnt == 0) ? 1 : 0);
      chk("wait_time", int'(bus.wait_time), m_wait);
      chk("overflow", int'(bus.overflow), m_ov);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.enter_pulse = 1'b0; bus.teller_on = '0; bus.teller_done = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_in();
    step(); step();
    chk("rst q_empty", int'(bus.q_empty), 1);
    chk("rst q_count", int'(bus.q_count), 0);
    chk("rst call_valid", int'(bus.call_valid), 0);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // 1: single teller, two waiting customers
    bus.enter_pulse = 1'b1; step(); step();
    bus.enter_pulse = 1'b0; bus.teller_on = 3'b001; step();
    chk("t1 count before call", int'(bus.q_count), 2);
    step();
    chk("t1 call_valid", int'(bus.call_valid), 1);
    chk("t1 call_id", int'(bus.call_id), 0);
    chk("t1 count after call", int'(bus.q_count), 1);
    chk("t1 wait_time", int'(bus.wait_time), 3);
    step(); step(); step();
    chk("t1 no second call", int'(bus.call_valid), 0);
    bus.teller_done = 3'b001; step();
    bus.teller_done = 3'b000; step();
    chk("t1 call after done", int'(bus.call_valid), 1);
    chk("t1 empty", int'(bus.q_empty), 1);

    // 2: three tellers, round-robin order
    do_reset();
    bus.teller_on = 3'b111; step();
    bus.enter_pulse = 1'b1; step(); step();
    chk("t2 id a", int'(bus.call_id), 0);
    step();
    chk("t2 id b", int'(bus.call_id), 1);
    bus.enter_pulse = 1'b0; step();
    chk("t2 id c", int'(bus.call_id), 2);
    chk("t2 empty", int'(bus.q_empty), 1);
    bus.teller_done = 3'b010; bus.enter_pulse = 1'b1; step();
    bus.teller_done = 3'b000; bus.enter_pulse = 1'b0; step();
    chk("t2 recall valid", int'(bus.call_valid), 1);
    chk("t2 recall id", int'(bus.call_id), 1);

    // 3: nobody on duty, fill and overflow
    do_reset();
    bus.enter_pulse = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("t3 full", int'(bus.q_full), 1);
    chk("t3 no early ovf", int'(bus.overflow), 0);
    step();
    chk("t3 overflow", int'(bus.overflow), 1);
    chk("t3 count", int'(bus.q_count), 7);
    chk("t3 wait sat", int'(bus.wait_time), 63);
    bus.enter_pulse = 1'b0; step();
    chk("t3 ovf one cycle", int'(bus.overflow), 0);

    // 4: full queue, arrival coincides with a call
    bus.teller_on = 3'b001; step();
    chk("t4 wait", int'(bus.wait_time), 21);
    bus.enter_pulse = 1'b1; step();
    bus.enter_pulse = 1'b0;
    chk("t4 count", int'(bus.q_count), 7);
    chk("t4 no ovf", int'(bus.overflow), 0);
    chk("t4 call", int'(bus.call_valid), 1);

    // 5: serving teller goes off duty, its done is ignored
    do_reset();
    bus.teller_on = 3'b010; bus.enter_pulse = 1'b1; step();
    bus.enter_pulse = 1'b0; step();
    chk("t5 call id", int'(bus.call_id), 1);
    bus.teller_on = 3'b000; step();
    bus.teller_done = 3'b010; bus.enter_pulse = 1'b1; step();
    bus.teller_done = 3'b000; bus.enter_pulse = 1'b0; step(); step();
    chk("t5 not granted", int'(bus.call_valid), 0);
    chk("t5 count", int'(bus.q_count), 1);

    // 6: async reset while a call is being issued
    do_reset();
    bus.enter_pulse = 1'b1;
    for (int k = 0; k < 5; k++) step();
    bus.enter_pulse = 1'b0; bus.teller_on = 3'b001; step(); step();
    chk("t6 call before rst", int'(bus.call_valid), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6 async cv", int'(bus.call_valid), 0);
    chk("t6 async count", int'(bus.q_count), 0);
    chk("t6 async empty", int'(bus.q_empty), 1);
    chk("t6 async wait", int'(bus.wait_time), 0);
    step(); step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6 quiet after rst", int'(bus.call_valid), 0);
    end
    bus.enter_pulse = 1'b1; step();
    bus.enter_pulse = 1'b0; step();
    chk("t6 call after enter", int'(bus.call_valid), 1);

    // random traffic, checked by the per-cycle compare
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.enter_pulse = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) bus.teller_on = N'($urandom);
      bus.teller_done = N'($urandom) & N'($urandom);
      step();
    end
    idle_in();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
